ppt_channel_array: RTL and testbench

Multi-channel successor to the single-channel programmable pulse train (PPT) generator and counter. It drives NCH independent pulse trains, each with its own period, width, pulse count, start phase offset and counted/continuous mode. All channels share one clock and one prescaler tick. The block sits between the register map (configuration writes, start/stop strobes, status readback) and the output pins.

---
 rtl/ppt_pkg.sv | 17 +
 rtl/ppt_channel.sv | 156 +++++++++++++++
 rtl/ppt_channel_array.sv | 58 +++++
 tb/tb_ppt_channel_array.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppt_pkg.sv
// Shared definitions for the multi-channel pulse train generator:
// configuration field selects and the per-channel state encoding.
package ppt_pkg;

    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_WIDTH  = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_PHASE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ch_state_t;

endpackage

// File: rtl/ppt_channel.sv
// One pulse train channel: shadow/active configuration, phase delay,
// period counter and emitted-pulse counter.
module ppt_channel
    import ppt_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [CW-1:0] cfg_data,
    input  logic          mode,
    input  logic          start,
    input  logic          stop,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] emitted
);

    logic [CW-1:0] sh_period, sh_width, sh_count, sh_phase;
    logic [CW-1:0] act_period, act_width, act_count;
    logic [CW-1:0] act_period_nx, act_width_nx, act_count_nx;
    logic          act_mode, act_mode_nx;
    ch_state_t     state, state_nx;
    logic [CW-1:0] pc, pc_nx, ph_cnt, ph_cnt_nx, emitted_nx, em_inc;
    logic          lead, lead_nx, pulse_nx, done_nx, accept;

    // NOTE: configuration registers get a reset value; they are a handful of flops, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_period <= '0;
            sh_width  <= '0;
            sh_count  <= '0;
            sh_phase  <= '0;
        end else if (cfg_we) begin
            case (cfg_sel)
                SEL_PERIOD: sh_period <= cfg_data;
                SEL_WIDTH:  sh_width  <= cfg_data;
                SEL_COUNT:  sh_count  <= cfg_data;
                default:    sh_phase  <= cfg_data;
            endcase
        end
    end

    assign accept = start && !stop && (sh_period >= CW'(2));
    assign em_inc = (emitted == '1) ? emitted : emitted + 1'b1;

    // NOTE: every output of this block is defaulted first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_nx      = state;
        act_period_nx = act_period;
        act_width_nx  = act_width;
        act_count_nx  = act_count;
        act_mode_nx   = act_mode;
        pc_nx         = pc;
        ph_cnt_nx     = ph_cnt;
        emitted_nx    = emitted;
        lead_nx       = lead;
        pulse_nx      = pulse_out;
        done_nx       = done;

        if (stop) begin
            state_nx = IDLE;
            pulse_nx = 1'b0;
            lead_nx  = 1'b0;
        end else if (accept) begin
            act_period_nx = sh_period;
            act_width_nx  = sh_width;
            act_count_nx  = sh_count;
            act_mode_nx   = mode;
            pc_nx         = '0;
            ph_cnt_nx     = sh_phase;
            emitted_nx    = '0;
            lead_nx       = 1'b0;
            done_nx       = 1'b0;
            if (!mode && (sh_count == '0)) begin
                state_nx = DONE;
                done_nx  = 1'b1;
                pulse_nx = 1'b0;
            end else if (sh_phase != '0) begin
                state_nx = PHASE;
                pulse_nx = 1'b0;
            end else begin
                state_nx = RUN;
                pulse_nx = (sh_width != '0);
            end
        end else if (tick) begin
            case (state)
                PHASE: begin
                    if (ph_cnt == CW'(1)) begin
                        state_nx = RUN;
                        lead_nx  = 1'b1;
                    end
                    ph_cnt_nx = ph_cnt - 1'b1;
                end
                RUN: begin
                    // After a phase delay, the first RUN tick only opens period 0.
                    if (lead) begin
                        lead_nx  = 1'b0;
                        pc_nx    = '0;
                        pulse_nx = (act_width != '0);
                    end else if (pc == act_period - 1'b1) begin
                        pc_nx      = '0;
                        emitted_nx = em_inc;
                        if (!act_mode && (em_inc == act_count)) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                            pulse_nx = 1'b0;
                        end else begin
                            pulse_nx = (act_width != '0);
                        end
                    end else begin
                        pc_nx    = pc + 1'b1;
                        pulse_nx = (pc_nx < act_width);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            act_period <= '0;
            act_width  <= '0;
            act_count  <= '0;
            act_mode   <= 1'b0;
            pc         <= '0;
            ph_cnt     <= '0;
            emitted    <= '0;
            lead       <= 1'b0;
            pulse_out  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            act_period <= act_period_nx;
            act_width  <= act_width_nx;
            act_count  <= act_count_nx;
            act_mode   <= act_mode_nx;
            pc         <= pc_nx;
            ph_cnt     <= ph_cnt_nx;
            emitted    <= emitted_nx;
            lead       <= lead_nx;
            pulse_out  <= pulse_nx;
            done       <= done_nx;
        end
    end

    assign busy = (state == PHASE) || (state == RUN);

endmodule

// File: rtl/ppt_channel_array.sv
// NCH independent pulse train channels sharing one clock and prescaler tick;
// the top only decodes configuration writes and muxes the readback count.
module ppt_channel_array
    import ppt_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_sel,
    input  logic [CW-1:0]  cfg_data,
    input  logic [NCH-1:0] mode,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] stop,
    input  logic [CHW-1:0] rd_ch,
    output logic [NCH-1:0] pulse_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done,
    output logic [CW-1:0]  rd_count
);

    logic [CW-1:0] emitted [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CHW'(i));

        ppt_channel #(.CW(CW)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .cfg_we    (ch_we),
            .cfg_sel   (cfg_sel),
            .cfg_data  (cfg_data),
            .mode      (mode[i]),
            .start     (start[i]),
            .stop      (stop[i]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .emitted   (emitted[i])
        );
    end

    // Indices with no channel behind them fall through to zero.
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) rd_count = emitted[i];
        end
    end

endmodule

// File: tb/tb_ppt_channel_array.sv
// Scoreboard bench for ppt_channel_array: stimulus queues per-cycle expectations,
// a negedge monitor compares whatever is due in the current cycle.
module tb_ppt_channel_array;
    import ppt_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int CHW = 2;

    typedef enum int {S_PULSE, S_BUSY, S_DONE, S_RD} sig_t;
    typedef struct {
        int            cyc;
        sig_t          sig;
        int            ch;
        logic [CW-1:0] val;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n, tick, cfg_we;
    logic [CHW-1:0] cfg_ch, rd_ch;
    logic [1:0]     cfg_sel;
    logic [CW-1:0]  cfg_data;
    logic [NCH-1:0] mode, start, stop;
    logic [NCH-1:0] pulse_out, busy, done;
    logic [CW-1:0]  rd_count;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   half_rate = 1'b0;
    int   tick_base = 0;
    exp_t exp_q[$];

    ppt_channel_array #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .rd_ch     (rd_ch),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string sig_name(input sig_t s);
        case (s)
            S_PULSE: return "pulse_out";
            S_BUSY:  return "busy";
            S_DONE:  return "done";
            default: return "rd_count";
        endcase
    endfunction

    function automatic void exp_at(input int c, input sig_t s, input int ch, input int v);
        exp_q.push_back('{cyc: c, sig: s, ch: ch, val: v[CW-1:0]});
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                logic [CW-1:0] act;
                case (exp_q[i].sig)
                    S_PULSE: act = {{(CW-1){1'b0}}, pulse_out[exp_q[i].ch]};
                    S_BUSY:  act = {{(CW-1){1'b0}}, busy[exp_q[i].ch]};
                    S_DONE:  act = {{(CW-1){1'b0}}, done[exp_q[i].ch]};
                    default: act = rd_count;
                endcase
                check($sformatf("%s[%0d]@%0d", sig_name(exp_q[i].sig), exp_q[i].ch, cyc),
                      act, exp_q[i].val);
                exp_q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start  = '0;
        stop   = '0;
        cfg_we = 1'b0;
        tick   = half_rate ? (((cyc + 1 - tick_base) % 2) == 0) : 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic write_cfg(input int ch, input logic [1:0] sel, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = ch[CHW-1:0];
        cfg_sel  = sel;
        cfg_data = data[CW-1:0];
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n = 1'b0; tick = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0;
        cfg_data = '0; mode = '0; start = '0; stop = '0; rd_ch = '0;
        step(); step();

        // Reset values
        for (int c = 0; c < NCH; c++) begin
            exp_at(cyc, S_PULSE, c, 0);
            exp_at(cyc, S_BUSY, c, 0);
            exp_at(cyc, S_DONE, c, 0);
        end
        exp_at(cyc, S_RD, 0, 0);
        step();
        rst_n = 1'b1;
        step();

        // Ch0 counted: period 5, width 2, count 3
        write_cfg(0, SEL_PERIOD, 5);
        write_cfg(0, SEL_WIDTH, 2);
        write_cfg(0, SEL_COUNT, 3);
        mode = 4'b0000;
        s = cyc + 1;
        exp_at(s - 1, S_BUSY, 0, 0);
        for (int k = 0; k < 15; k++) begin
            exp_at(s + k, S_PULSE, 0, int'((k % 5) < 2));
            exp_at(s + k, S_BUSY, 0, 1);
        end
        exp_at(s + 14, S_DONE, 0, 0);
        exp_at(s + 15, S_BUSY, 0, 0);
        exp_at(s + 15, S_DONE, 0, 1);
        exp_at(s + 15, S_PULSE, 0, 0);
        start = 4'b0001;
        step();
        wait_cycles(16);
        rd_ch = 2'd0;
        exp_at(cyc, S_RD, 0, 3);
        step();

        // Ch1 continuous with phase 4, period 4, width 1, tick every 2nd cycle
        write_cfg(1, SEL_PERIOD, 4);
        write_cfg(1, SEL_WIDTH, 1);
        write_cfg(1, SEL_PHASE, 4);
        mode = 4'b0010;
        s = cyc + 1;
        half_rate = 1'b1;
        tick_base = s;
        tick = 1'b1;
        for (int k = 0; k < 42; k++) begin
            exp_at(s + k, S_PULSE, 1, int'(k >= 10 && ((k - 10) % 8) < 2));
        end
        exp_at(s, S_BUSY, 1, 1);
        exp_at(s + 9, S_BUSY, 1, 1);
        exp_at(s + 41, S_BUSY, 1, 1);
        exp_at(s + 42, S_PULSE, 1, 0);
        exp_at(s + 42, S_BUSY, 1, 0);
        exp_at(s + 42, S_DONE, 1, 0);
        exp_at(s + 44, S_PULSE, 1, 0);
        start = 4'b0010;
        step();
        wait_cycles(41);
        stop = 4'b0010;
        step();
        half_rate = 1'b0;
        tick = 1'b1;
        rd_ch = 2'd1;
        exp_at(cyc, S_RD, 1, 3);
        wait_cycles(3);

        // period=1 start is ignored
        write_cfg(2, SEL_PERIOD, 1);
        mode = 4'b0000;
        s = cyc + 1;
        exp_at(s, S_BUSY, 2, 0);
        exp_at(s, S_PULSE, 2, 0);
        exp_at(s + 1, S_BUSY, 2, 0);
        start = 4'b0100;
        step(); step();

        // count=0: done right after start, no pulse
        write_cfg(3, SEL_PERIOD, 5);
        write_cfg(3, SEL_WIDTH, 2);
        write_cfg(3, SEL_COUNT, 0);
        s = cyc + 1;
        exp_at(s - 1, S_DONE, 3, 0);
        exp_at(s, S_DONE, 3, 1);
        exp_at(s, S_BUSY, 3, 0);
        exp_at(s, S_PULSE, 3, 0);
        exp_at(s + 1, S_PULSE, 3, 0);
        start = 4'b1000;
        step(); step();

        // width 7 >= period 5: constant high for 2 periods
        write_cfg(0, SEL_WIDTH, 7);
        write_cfg(0, SEL_COUNT, 2);
        s = cyc + 1;
        exp_at(s, S_DONE, 0, 0);
        for (int k = 0; k < 10; k++) exp_at(s + k, S_PULSE, 0, 1);
        exp_at(s + 9, S_BUSY, 0, 1);
        exp_at(s + 10, S_PULSE, 0, 0);
        exp_at(s + 10, S_BUSY, 0, 0);
        exp_at(s + 10, S_DONE, 0, 1);
        start = 4'b0001;
        step();
        wait_cycles(10);

        // Ch2 period 6; shadow rewritten to 3 mid-train
        write_cfg(2, SEL_PERIOD, 6);
        write_cfg(2, SEL_WIDTH, 3);
        write_cfg(2, SEL_COUNT, 3);
        s = cyc + 1;
        for (int k = 0; k < 18; k++) exp_at(s + k, S_PULSE, 2, int'((k % 6) < 3));
        exp_at(s + 17, S_BUSY, 2, 1);
        exp_at(s + 18, S_BUSY, 2, 0);
        exp_at(s + 18, S_DONE, 2, 1);
        start = 4'b0100;
        step();
        wait_cycles(3);
        write_cfg(2, SEL_PERIOD, 3);
        wait_cycles(15);
        s = cyc + 1;
        exp_at(s, S_DONE, 2, 0);
        for (int k = 0; k < 9; k++) exp_at(s + k, S_PULSE, 2, 1);
        exp_at(s + 8, S_BUSY, 2, 1);
        exp_at(s + 9, S_BUSY, 2, 0);
        exp_at(s + 9, S_DONE, 2, 1);
        start = 4'b0100;
        step();
        wait_cycles(10);

        // start and stop together: stop wins, done untouched
        write_cfg(3, SEL_COUNT, 2);
        s = cyc + 1;
        exp_at(s, S_BUSY, 3, 0);
        exp_at(s, S_DONE, 3, 1);
        exp_at(s, S_PULSE, 3, 0);
        exp_at(s + 1, S_BUSY, 3, 0);
        start = 4'b1000;
        stop  = 4'b1000;
        step(); step();

        // cfg write and start together: start uses the old width (7)
        s = cyc + 1;
        for (int k = 0; k < 10; k++) exp_at(s + k, S_PULSE, 0, 1);
        exp_at(s + 10, S_DONE, 0, 1);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = SEL_WIDTH; cfg_data = '0;
        start = 4'b0001;
        step();
        wait_cycles(10);
        s = cyc + 1;
        exp_at(s, S_BUSY, 0, 1);
        for (int k = 0; k < 3; k++) exp_at(s + k, S_PULSE, 0, 0);
        start = 4'b0001;
        step();
        wait_cycles(3);

        // Async reset mid-run on all channels
        mode = 4'b1111;
        start = 4'b1111;
        step();
        wait_cycles(4);
        for (int c = 0; c < NCH; c++) exp_at(cyc, S_BUSY, c, 1);
        exp_at(cyc, S_PULSE, 2, 1);
        step();
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_at(cyc, S_PULSE, c, 0);
            exp_at(cyc, S_BUSY, c, 0);
            exp_at(cyc, S_DONE, c, 0);
        end
        step();
        rst_n = 1'b1;
        step();
        s = cyc + 1;
        for (int c = 0; c < NCH; c++) exp_at(s, S_BUSY, c, 0);
        exp_at(s, S_RD, 1, 0);
        start = 4'b1111;
        step();
        wait_cycles(2);

        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            errors++;
            $display("FAIL unchecked %s[%0d]@%0d: never sampled, expected %0d",
                     sig_name(exp_q[i].sig), exp_q[i].ch, exp_q[i].cyc, exp_q[i].val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
